// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
//
// Holds the PC, fetches one instruction word per retire from a word-addressed
// instruction memory, presents the registered instruction plus its decoded
// fields, and computes the next PC when downstream retires the instruction.
//
// Handshakes:
//   imem_req/imem_ready : a fetch completes on any rising edge where
//                         imem_req && imem_ready; imem_addr is held stable
//                         while imem_req is high, and imem_rdata is sampled
//                         only on that completing edge.
//   instr_valid/instr_ready : the instruction retires on any rising edge
//                         where instr_valid && instr_ready; pc_src,
//                         target_sel, imm and rs1_data are sampled only then.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/addr/ready/rdata   instruction memory interface
//   instr_valid/instr_ready     handshake with decode/control
//   pc_src, target_sel, imm, rs1_data  next-PC decision from retire
//   pc, pc_plus4, instr, opcode, funct3, funct7, rd, rs1, rs2  fetch outputs
//   fault, fault_pc       sticky misaligned-target flag and offending address
//   retire_count          count of accepted instructions (wraps)
//   dbg_state             current FSM state (IDLE=0, FETCH=1, HOLD=2, FAULT=3)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_src,
    input  logic [1:0]  target_sel,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] retire_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_fault;
    logic [31:0] r_fault_pc;
    logic [31:0] r_retire_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_fetch_done;
    logic        w_accept;
    logic        w_misaligned;

    // Next-PC arithmetic; all additions are modular 32-bit.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jalr_sum = rs1_data + imm;
    // jalr clears bit 0 before the alignment check, so only bit 1 can fault.
    assign w_target   = (target_sel == 2'b00) ? {w_jalr_sum[31:1], 1'b0}
                                              : (r_pc + imm);
    assign w_next_pc  = pc_src ? w_target : w_pc_plus4;

    assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
    assign w_accept     = (r_state == S_HOLD) && instr_ready;
    assign w_misaligned = (w_next_pc[1:0] != 2'b00);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: if (imem_ready) w_next_state = S_HOLD;
            S_HOLD:  if (instr_ready) w_next_state = w_misaligned ? S_FAULT : S_FETCH;
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_instr        <= NOP;
            r_fault        <= 1'b0;
            r_fault_pc     <= 32'd0;
            r_retire_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_fetch_done) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_retire_count <= r_retire_count + 32'd1;
                if (w_misaligned) begin
                    // PC stays on the instruction that produced the bad target.
                    r_fault    <= 1'b1;
                    r_fault_pc <= w_next_pc;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = r_pc;
    assign instr_valid  = (r_state == S_HOLD);
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign instr        = r_instr;
    // Fields decode the registered word so they stay stable during HOLD.
    assign opcode       = r_instr[6:0];
    assign rd           = r_instr[11:7];
    assign funct3       = r_instr[14:12];
    assign rs1          = r_instr[19:15];
    assign rs2          = r_instr[24:20];
    assign funct7       = r_instr[31:25];
    assign fault        = r_fault;
    assign fault_pc     = r_fault_pc;
    assign retire_count = r_retire_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table of retire vectors plus hand-written
// sequences for reset, fault and mid-fetch reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [1:0]  target_sel;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] retire_count;
    logic [1:0]  dbg_state;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_src(pc_src), .target_sel(target_sel), .imm(imm), .rs1_data(rs1_data),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .fault(fault), .fault_pc(fault_pc), .retire_count(retire_count),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pc_src;
        logic [1:0]  tsel;
        logic [31:0] imm;
        logic [31:0] rs1;
        int          waits;
        int          holds;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h0019_660D + 32'h3C6E_F35F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_side_inputs();
        pc_src     = 1'($urandom_range(0, 1));
        target_sel = 2'($urandom_range(0, 3));
        imm        = $urandom;
        rs1_data   = $urandom;
    endtask

    // Scoreboard pop: compare held instruction and its fields.
    task automatic check_hold_entry();
        check32("hold_valid", {31'd0, instr_valid}, 32'd1);
        check32("hold_req", {31'd0, imem_req}, 32'd0);
        if (exp_q.size() == 0) begin
            check32("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        m_instr = exp_q.pop_front();
        check32("instr", instr, m_instr);
        check32("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
        check32("rd", {27'd0, rd}, {27'd0, m_instr[11:7]});
        check32("funct3", {29'd0, funct3}, {29'd0, m_instr[14:12]});
        check32("rs1", {27'd0, rs1}, {27'd0, m_instr[19:15]});
        check32("rs2", {27'd0, rs2}, {27'd0, m_instr[24:20]});
        check32("funct7", {25'd0, funct7}, {25'd0, m_instr[31:25]});
        check32("hold_pc", pc, m_pc);
        check32("pc_plus4", pc_plus4, m_pc + 32'd4);
    endtask

    // Memory driver: answer one fetch at m_pc after 'waits' wait cycles.
    task automatic serve_fetch(input int waits, input int max_idle);
        int n;
        n = 0;
        while (!imem_req && n < max_idle) begin
            tick();
            n++;
        end
        check32("fetch_req", {31'd0, imem_req}, 32'd1);
        if (!imem_req) return;
        check32("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = ~mem_word(m_pc);
            tick();
            check32("wait_req", {31'd0, imem_req}, 32'd1);
            check32("wait_addr", imem_addr, m_pc);
            check32("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = mem_word(m_pc);
        exp_q.push_back(mem_word(m_pc));
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check_hold_entry();
    endtask

    // Downstream driver: back-pressure for 'holds' cycles, then retire.
    task automatic hold_and_retire(input int holds, input logic src, input logic [1:0] ts,
                                   input logic [31:0] im, input logic [31:0] r1);
        for (int i = 0; i < holds; i++) begin
            instr_ready = 1'b0;
            randomize_side_inputs();
            // Memory noise during HOLD must be ignored.
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            tick();
            check32("bp_instr", instr, m_instr);
            check32("bp_pc", pc, m_pc);
            check32("bp_rd", {27'd0, rd}, {27'd0, m_instr[11:7]});
            check32("bp_req", {31'd0, imem_req}, 32'd0);
            check32("bp_valid", {31'd0, instr_valid}, 32'd1);
            check32("bp_count", retire_count, m_count);
        end
        imem_ready  = 1'b0;
        instr_ready = 1'b1;
        pc_src      = src;
        target_sel  = ts;
        imm         = im;
        rs1_data    = r1;
        tick();
        instr_ready = 1'b0;
        randomize_side_inputs();
        m_count = m_count + 32'd1;
        check32("retire_count", retire_count, m_count);
        check32("post_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        // Retire vectors: each starts from the previous entry's exp_pc (first from 0).
        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0004};
        vecs[1]  = '{1'b0, 2'b01, 32'h0000_1000, 32'h0000_0000, 0, 0, 32'h0000_0008};
        vecs[2]  = '{1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_000C};
        vecs[3]  = '{1'b1, 2'b01, 32'h0000_0004, 32'h0000_0000, 0, 0, 32'h0000_0010};
        vecs[4]  = '{1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 3, 0, 32'h0000_0020};
        vecs[5]  = '{1'b1, 2'b01, 32'hFFFF_FFF0, 32'h0000_0000, 0, 0, 32'h0000_0010};
        vecs[6]  = '{1'b1, 2'b11, 32'h0000_0010, 32'h0000_0000, 0, 1, 32'h0000_0020};
        vecs[7]  = '{1'b0, 2'b01, 32'hFFFF_FFF0, 32'h0000_0000, 0, 0, 32'h0000_0024};
        vecs[8]  = '{1'b1, 2'b00, 32'h0000_0003, 32'h0000_0101, 0, 5, 32'h0000_0104};
        vecs[9]  = '{1'b1, 2'b00, 32'h0000_0000, 32'h0000_0201, 1, 0, 32'h0000_0200};
        vecs[10] = '{1'b1, 2'b00, 32'h0000_0041, 32'hFFFF_FFFF, 2, 2, 32'h0000_0040};

        rst = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        instr_ready = 1'b1;
        randomize_side_inputs();
        m_pc = 32'd0;
        m_count = 32'd0;
        m_instr = 32'h0000_0013;

        // Reset state (inputs active during reset must be overridden).
        repeat (2) tick();
        check32("rst_instr", instr, 32'h0000_0013);
        check32("rst_opcode", {25'd0, opcode}, 32'h0000_0013);
        check32("rst_pc", pc, 32'd0);
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_fault", {31'd0, fault}, 32'd0);
        check32("rst_fault_pc", fault_pc, 32'd0);
        check32("rst_count", retire_count, 32'd0);
        rst = 1'b0;
        instr_ready = 1'b0;
        imem_ready = 1'b0;

        // Table-driven fetch/retire run.
        for (int v = 0; v < 11; v++) begin
            serve_fetch(vecs[v].waits, (v == 0) ? 1 : 0);
            hold_and_retire(vecs[v].holds, vecs[v].pc_src, vecs[v].tsel,
                            vecs[v].imm, vecs[v].rs1);
            m_pc = vecs[v].exp_pc;
            check32("next_pc", pc, m_pc);
            check32("no_fault", {31'd0, fault}, 32'd0);
        end

        // Reset while a fetch at 0x40 is waiting on memory.
        check32("midrst_req", {31'd0, imem_req}, 32'd1);
        check32("midrst_addr", imem_addr, 32'h0000_0040);
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("midrst_pc", pc, 32'd0);
        check32("midrst_req0", {31'd0, imem_req}, 32'd0);
        check32("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check32("midrst_count", retire_count, 32'd0);
        check32("midrst_instr", instr, 32'h0000_0013);
        m_pc = 32'd0;
        m_count = 32'd0;
        serve_fetch(0, 1);

        // jalr with a bit-1 misaligned target: terminal fault.
        hold_and_retire(0, 1'b1, 2'b00, 32'h0000_0000, 32'h0000_0102);
        check32("fault_flag", {31'd0, fault}, 32'd1);
        check32("fault_pc", fault_pc, 32'h0000_0102);
        check32("fault_pc_hold", pc, 32'd0);
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b1;
            imem_ready = 1'b1;
            imem_rdata = $urandom;
            tick();
            check32("fault_req", {31'd0, imem_req}, 32'd0);
            check32("fault_valid", {31'd0, instr_valid}, 32'd0);
            check32("fault_sticky", {31'd0, fault}, 32'd1);
            check32("fault_count", retire_count, 32'd1);
        end
        instr_ready = 1'b0;
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("fault_clear", {31'd0, fault}, 32'd0);
        check32("fault_pc_clear", fault_pc, 32'd0);
        m_pc = 32'd0;
        m_count = 32'd0;

        // pc+imm misaligned target faults too.
        serve_fetch(1, 1);
        hold_and_retire(1, 1'b1, 2'b01, 32'h0000_0006, 32'h0000_0000);
        check32("fault2_flag", {31'd0, fault}, 32'd1);
        check32("fault2_pc", fault_pc, 32'h0000_0006);
        tick();
        check32("fault2_req", {31'd0, imem_req}, 32'd0);

        check32("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
